mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
MEM-stage consumer of the EX/MEM pipeline register outputs. It turns the registered load/store request into a held data-cache request (dmemREN/dmemWEN, held until dhit) and stalls the pipeline while the request is outstanding. It implements LL/SC through a link register that is invalidated by coherence snoops. It delivers the load data and the SC result toward the MEM/WB register.

Parameters:
ADDR_W, 32, address/data word width
STALL_CNT_W, 32, width of the saturating stall-cycle performance counter

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
req_ren  input  1  load request from EX/MEM (Mem_Read)
req_wen  input  1  store request from EX/MEM (Mem_Write)
req_atomic  input  1  request is LL (with ren) or SC (with wen)
req_addr  input  ADDR_W  effective address (final_memaddr)
req_wdat  input  ADDR_W  store data (rdat2)
flush  input  1  squash the current EX/MEM entry
dhit  input  1  data cache completion
dmemload  input  ADDR_W  cache read data
snoop_inv  input  1  coherence invalidation valid
snoop_addr  input  ADDR_W  invalidated address
dmemREN  output  1  cache read request
dmemWEN  output  1  cache write request
dmemaddr  output  ADDR_W  cache address
dmemstore  output  ADDR_W  cache write data
stall  output  1  hold the EX/MEM register and the upstream stages
mem_done  output  1  one-cycle completion pulse
mem_rdata  output  ADDR_W  load data, or SC result (0/1) for SC
link_valid  output  1  reservation held (debug)
stall_cycles  output  STALL_CNT_W  saturating count of cycles with stall=1

Behaviour:
- Reset (asynchronous, nRST=0): state=IDLE. All outputs are 0, link_valid=0, link_addr=0, stall_cycles=0. Reset mid-ACCESS abandons the request; no completion pulse is produced.
- new_req = (req_ren|req_wen) & ~flush, sampled only in IDLE. If both ren and wen are set, the request is treated as a write.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, new_req=0: stay in IDLE; stall=0.
- IDLE, new_req=1, SC that fails (link_valid=0, or link_addr[31:2]≠req_addr[31:2], or a matching snoop_inv in the same cycle): go to DONE; latch mem_rdata=0; issue no cache access. stall=1 in this cycle.
- IDLE, any other new_req: latch addr, wdat, type and atomic; go to ACCESS. stall=1 in this cycle.
- ACCESS: dmemREN or dmemWEN = the latched type; dmemaddr and dmemstore come from the latches and are held stable until dhit. stall=1.
  - On dhit: go to DONE.
  - Read: latch mem_rdata=dmemload.
  - SC write: latch mem_rdata=1.
  - Plain write: latch mem_rdata=0.
- DONE: mem_done=1, stall=0, request outputs low; the EX/MEM register advances on this edge. Request inputs are ignored this cycle. Next state is IDLE.
- Minimum latency: 3 cycles accept→done when dhit arrives the first cycle in ACCESS; 2 cycles for a failed SC.
- flush is honoured only in IDLE. Once in ACCESS the request completes, because the cache transaction is already committed.
- Link register:
  - LL completing on dhit sets link_valid=1 and link_addr=addr.
  - Any completing write (SC or plain) to the same word clears link_valid.
  - A failed SC also clears link_valid.
  - snoop_inv with snoop_addr[31:2]=link_addr[31:2] clears link_valid in any state.
- Simultaneous events:
  - Snoop in the cycle LL's dhit arrives: the LL sets the link, i.e. the set wins over the snoop clear.
  - Snoop during SC ACCESS: the write is already issued and the SC result stays 1.
- stall_cycles increments each cycle stall=1 and saturates at all-ones.

Test Plan:
- LW addr 0x100, dhit 2 cycles after ACCESS entry, dmemload=0xDEADBEEF → dmemREN high for exactly 2 cycles, then mem_done pulse with mem_rdata=0xDEADBEEF; stall high for 3 cycles; stall_cycles=3.
- SW addr 0x200, wdat 0x1234, dhit immediate → dmemWEN=1, dmemaddr=0x200, dmemstore=0x1234 for 1 cycle, then mem_done, mem_rdata=0.
- LL 0x300 then SC 0x300 wdat 5 with no snoop → link_valid=1 after LL; SC issues dmemWEN, mem_rdata=1; link_valid=0 afterwards.
- LL 0x300, then snoop_inv 0x304 (different word), then snoop_inv 0x300, then SC 0x300 → link survives the first snoop and clears on the second; SC produces no dmemWEN, mem_done 1 cycle after acceptance, mem_rdata=0.
- Load presented with flush=1 in IDLE → no dmemREN, stall=0, no mem_done. Then nRST pulsed low during ACCESS of a store → outputs 0 immediately, state IDLE, link_valid=0.
- Hold dhit low for 2^STALL_CNT_W+ cycles (STALL_CNT_W=4 build) → stall_cycles saturates at 15 with no wrap.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: turns the EX/MEM load/store into a held data-cache request,
// stalls the pipeline while it is outstanding, and implements LL/SC with a snoop-invalidated link.
module mem_access_unit #(
  parameter int ADDR_W      = 32,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   req_ren,
  input  logic                   req_wen,
  input  logic                   req_atomic,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [ADDR_W-1:0]      req_wdat,
  input  logic                   flush,
  input  logic                   dhit,
  input  logic [ADDR_W-1:0]      dmemload,
  input  logic                   snoop_inv,
  input  logic [ADDR_W-1:0]      snoop_addr,
  output logic                   dmemREN,
  output logic                   dmemWEN,
  output logic [ADDR_W-1:0]      dmemaddr,
  output logic [ADDR_W-1:0]      dmemstore,
  output logic                   stall,
  output logic                   mem_done,
  output logic [ADDR_W-1:0]      mem_rdata,
  output logic                   link_valid,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [ADDR_W-1:0]      wdat_q, wdat_d;
  logic [ADDR_W-1:0]      rdata_q, rdata_d;
  logic [ADDR_W-1:0]      link_addr_q, link_addr_d;
  logic                   wr_q, wr_d;
  logic                   atomic_q, atomic_d;
  logic                   link_valid_q, link_valid_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic new_req_s;
  logic snoop_hit_s;
  logic sc_fail_s;
  logic stall_s;
  logic sc_clr_s;
  logic acc_hit_s;
  logic ll_set_s;
  logic wr_clr_s;
  logic unused_snoop_lsb_s;

  // Only word address bits take part in link comparisons.
  assign unused_snoop_lsb_s = ^snoop_addr[1:0];

  assign new_req_s   = (req_ren | req_wen) & ~flush;
  assign snoop_hit_s = snoop_inv & (snoop_addr[ADDR_W-1:2] == link_addr_q[ADDR_W-1:2]);
  assign sc_fail_s   = req_wen & req_atomic &
                       (~link_valid_q |
                        (link_addr_q[ADDR_W-1:2] != req_addr[ADDR_W-1:2]) |
                        snoop_hit_s);

  assign acc_hit_s = (state_q == ACCESS) & dhit;
  assign ll_set_s  = acc_hit_s & ~wr_q & atomic_q;
  assign wr_clr_s  = acc_hit_s & wr_q & (link_addr_q[ADDR_W-1:2] == addr_q[ADDR_W-1:2]);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdat_q       <= '0;
      rdata_q      <= '0;
      wr_q         <= 1'b0;
      atomic_q     <= 1'b0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdat_q       <= wdat_d;
      rdata_q      <= rdata_d;
      wr_q         <= wr_d;
      atomic_q     <= atomic_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    wr_d     = wr_q;
    atomic_d = atomic_q;
    rdata_d  = rdata_q;
    stall_s  = 1'b0;
    sc_clr_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (new_req_s) begin
          stall_s = 1'b1;
          if (sc_fail_s) begin
            // A failed SC never touches the cache; it just reports 0.
            state_d  = DONE;
            rdata_d  = '0;
            sc_clr_s = 1'b1;
          end else begin
            state_d  = ACCESS;
            addr_d   = req_addr;
            wdat_d   = req_wdat;
            wr_d     = req_wen;
            atomic_d = req_atomic;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        stall_s = 1'b1;
        if (dhit) begin
          state_d = DONE;
          if (!wr_q) begin
            rdata_d = dmemload;
          end else if (atomic_q) begin
            rdata_d = ADDR_W'(1);
          end else begin
            rdata_d = '0;
          end
        end else begin
          state_d = ACCESS;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A completing LL outranks every clear source, including a same-cycle snoop.
  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (ll_set_s) begin
      link_valid_d = 1'b1;
      link_addr_d  = addr_q;
    end else if (wr_clr_s | sc_clr_s | snoop_hit_s) begin
      link_valid_d = 1'b0;
    end else begin
      link_valid_d = link_valid_q;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_s && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  assign dmemREN      = (state_q == ACCESS) & ~wr_q;
  assign dmemWEN      = (state_q == ACCESS) & wr_q;
  assign dmemaddr     = addr_q;
  assign dmemstore    = wdat_q;
  assign stall        = stall_s & nRST;
  assign mem_done     = (state_q == DONE);
  assign mem_rdata    = rdata_q;
  assign link_valid   = link_valid_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit: an abstract LL/SC + memory model predicts
// cache accesses, results, link state and stall counts; monitors compare as the DUT responds.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        req_ren = 1'b0, req_wen = 1'b0, req_atomic = 1'b0, flush = 1'b0;
  logic        dhit = 1'b0, snoop_inv = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdat = 32'd0, dmemload = 32'd0, snoop_addr = 32'd0;
  logic        dmemREN, dmemWEN, stall, mem_done, link_valid;
  logic [31:0] dmemaddr, dmemstore, mem_rdata, stall_cycles;

  logic        s_req_ren = 1'b0, s_dhit = 1'b0;
  logic [31:0] s_req_addr = 32'd0, s_dmemload = 32'd0;
  logic        s_dmemREN, s_dmemWEN, s_stall, s_mem_done, s_link_valid;
  logic [31:0] s_dmemaddr, s_dmemstore, s_mem_rdata;
  logic [3:0]  s_stall_cycles;

  always #5 CLK = ~CLK;

  mem_access_unit #(.ADDR_W(32), .STALL_CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .req_ren(req_ren), .req_wen(req_wen), .req_atomic(req_atomic),
    .req_addr(req_addr), .req_wdat(req_wdat), .flush(flush), .dhit(dhit), .dmemload(dmemload),
    .snoop_inv(snoop_inv), .snoop_addr(snoop_addr), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .stall(stall), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .link_valid(link_valid), .stall_cycles(stall_cycles)
  );

  mem_access_unit #(.ADDR_W(32), .STALL_CNT_W(4)) dut_sat (
    .CLK(CLK), .nRST(nRST), .req_ren(s_req_ren), .req_wen(1'b0), .req_atomic(1'b0),
    .req_addr(s_req_addr), .req_wdat(32'd0), .flush(1'b0), .dhit(s_dhit), .dmemload(s_dmemload),
    .snoop_inv(1'b0), .snoop_addr(32'd0), .dmemREN(s_dmemREN), .dmemWEN(s_dmemWEN),
    .dmemaddr(s_dmemaddr), .dmemstore(s_dmemstore), .stall(s_stall), .mem_done(s_mem_done),
    .mem_rdata(s_mem_rdata), .link_valid(s_link_valid), .stall_cycles(s_stall_cycles)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  acc_t        exp_acc[$];
  logic [31:0] exp_res[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model state
  bit          m_link_v = 1'b0;
  logic [31:0] m_link_a = 32'd0;
  logic [31:0] m_stall  = 32'd0;
  logic [31:0] m_mem[int];
  logic [31:0] r_mem[int];

  int          resp_lat = 0;
  int          acc_cnt  = 0;
  bit          snp_dhit = 1'b0;
  logic [31:0] snp_dhit_addr = 32'd0;
  acc_t        resp_a;

  function automatic logic [31:0] init_val(input int w);
    logic [31:0] wv;
    wv = w;
    return {wv[15:0], 16'hC0DE};
  endfunction

  function automatic logic [31:0] m_rd(input int w);
    return m_mem.exists(w) ? m_mem[w] : init_val(w);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cache responder: raises dhit after resp_lat waiting cycles and checks the request
  always @(negedge CLK) begin
    if (nRST && (dmemREN || dmemWEN)) begin
      if (acc_cnt >= resp_lat) begin
        dhit    = 1'b1;
        acc_cnt = 0;
        if (exp_acc.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_access: got addr %h expected no access", dmemaddr);
        end else begin
          resp_a = exp_acc.pop_front();
          chk("acc_wen", {31'd0, dmemWEN}, {31'd0, resp_a.wr});
          chk("acc_ren", {31'd0, dmemREN}, {31'd0, ~resp_a.wr});
          chk("acc_addr", dmemaddr, resp_a.addr);
          if (resp_a.wr) chk("acc_store", dmemstore, resp_a.data);
        end
        if (dmemWEN) r_mem[int'(dmemaddr[31:2])] = dmemstore;
        else dmemload = r_mem.exists(int'(dmemaddr[31:2])) ? r_mem[int'(dmemaddr[31:2])]
                                                           : init_val(int'(dmemaddr[31:2]));
        if (snp_dhit) begin
          snoop_inv  = 1'b1;
          snoop_addr = snp_dhit_addr;
        end
      end else begin
        dhit = 1'b0;
        acc_cnt++;
      end
    end else begin
      dhit    = 1'b0;
      acc_cnt = 0;
    end
  end

  // Result monitor: every completion pulse must match the oldest predicted result
  always @(negedge CLK) begin
    if (nRST && mem_done) begin
      if (exp_res.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got mem_done=1 expected none, rdata %h", mem_rdata);
      end else begin
        chk("mem_rdata", mem_rdata, exp_res.pop_front());
      end
    end
  end

  task automatic do_txn(input bit ren, input bit wen, input bit at, input logic [31:0] addr,
                        input logic [31:0] wdat, input int lat, input bit snp_now,
                        input bit snp_hit, input logic [31:0] saddr);
    bit          is_sc, is_ll, hit_now, failed;
    logic [31:0] res;
    int          waited, exp_wait;
    is_sc   = wen & at;
    is_ll   = ren & ~wen & at;
    hit_now = snp_now && m_link_v && (saddr[31:2] == m_link_a[31:2]);
    failed  = is_sc && (!m_link_v || (m_link_a[31:2] != addr[31:2]) || hit_now);
    if (failed) begin
      m_link_v = 1'b0;
      exp_res.push_back(32'd0);
      m_stall  = m_stall + 32'd1;
      exp_wait = 0;
    end else begin
      if (hit_now) m_link_v = 1'b0;
      exp_acc.push_back('{wen, addr, wdat});
      m_stall  = m_stall + 32'd2 + 32'(lat);
      exp_wait = lat + 1;
      if (wen) begin
        m_mem[int'(addr[31:2])] = wdat;
        res = is_sc ? 32'd1 : 32'd0;
      end else begin
        res = m_rd(int'(addr[31:2]));
      end
      if (snp_hit && !is_ll && (saddr[31:2] == m_link_a[31:2])) m_link_v = 1'b0;
      if (is_ll) begin
        m_link_v = 1'b1;
        m_link_a = addr;
      end else if (wen && (m_link_a[31:2] == addr[31:2])) begin
        m_link_v = 1'b0;
      end
      exp_res.push_back(res);
    end
    @(negedge CLK);
    resp_lat      = lat;
    snp_dhit      = snp_hit;
    snp_dhit_addr = saddr;
    req_ren = ren; req_wen = wen; req_atomic = at; req_addr = addr; req_wdat = wdat;
    if (snp_now) begin
      snoop_inv  = 1'b1;
      snoop_addr = saddr;
    end
    @(negedge CLK);
    if (snp_now) snoop_inv = 1'b0;
    waited = 0;
    while (!mem_done && waited < 64) begin
      @(negedge CLK);
      waited++;
    end
    chk("latency", 32'(waited), 32'(exp_wait));
    chk("link_valid", {31'd0, link_valid}, {31'd0, m_link_v});
    chk("stall_cycles", stall_cycles, m_stall);
    req_ren = 1'b0; req_wen = 1'b0; req_atomic = 1'b0;
    if (snp_hit) snoop_inv = 1'b0;
    snp_dhit = 1'b0;
  endtask

  task automatic idle_snoop(input logic [31:0] saddr);
    @(negedge CLK);
    snoop_inv  = 1'b1;
    snoop_addr = saddr;
    if (m_link_v && (saddr[31:2] == m_link_a[31:2])) m_link_v = 1'b0;
    @(negedge CLK);
    snoop_inv = 1'b0;
    chk("snoop_link", {31'd0, link_valid}, {31'd0, m_link_v});
  endtask

  task automatic flushed_load(input logic [31:0] addr);
    @(negedge CLK);
    req_ren = 1'b1; flush = 1'b1; req_addr = addr;
    #1;
    chk("flush_stall", {31'd0, stall}, 32'd0);
    @(negedge CLK);
    chk("flush_ren", {31'd0, dmemREN}, 32'd0);
    chk("flush_cnt", stall_cycles, m_stall);
    req_ren = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          op, lat;
    logic [31:0] a, sa, wd;
    bit          sn, sh, rn;
    repeat (3) @(negedge CLK);
    chk("rst_ren", {31'd0, dmemREN}, 32'd0);
    chk("rst_wen", {31'd0, dmemWEN}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_done", {31'd0, mem_done}, 32'd0);
    chk("rst_link", {31'd0, link_valid}, 32'd0);
    chk("rst_cnt", stall_cycles, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_addr", dmemaddr, 32'd0);
    nRST = 1'b1;

    m_mem[32'h100 >> 2] = 32'hDEADBEEF;
    r_mem[32'h100 >> 2] = 32'hDEADBEEF;
    do_txn(1, 0, 0, 32'h100, 32'd0, 1, 0, 0, 32'd0);
    do_txn(0, 1, 0, 32'h200, 32'h1234, 0, 0, 0, 32'd0);
    do_txn(1, 0, 1, 32'h300, 32'd0, 0, 0, 0, 32'd0);
    do_txn(0, 1, 1, 32'h300, 32'd5, 0, 0, 0, 32'd0);
    do_txn(1, 0, 1, 32'h300, 32'd0, 0, 0, 0, 32'd0);
    idle_snoop(32'h304);
    idle_snoop(32'h300);
    do_txn(0, 1, 1, 32'h300, 32'd7, 0, 0, 0, 32'd0);
    flushed_load(32'h100);
    do_txn(1, 0, 1, 32'h310, 32'd0, 0, 0, 0, 32'd0);
    do_txn(1, 0, 1, 32'h310, 32'd0, 1, 0, 1, 32'h310);
    do_txn(0, 1, 1, 32'h310, 32'd9, 1, 0, 1, 32'h310);
    do_txn(1, 0, 1, 32'h320, 32'd0, 0, 0, 0, 32'd0);
    do_txn(0, 1, 1, 32'h320, 32'd3, 0, 1, 0, 32'h322);
    do_txn(1, 1, 0, 32'h330, 32'hCAFE, 2, 0, 0, 32'd0);
    do_txn(1, 0, 0, 32'h330, 32'd0, 0, 0, 0, 32'd0);

    for (int i = 0; i < 60; i++) begin
      op  = $urandom_range(0, 4);
      a   = 32'h400 + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
      sa  = 32'h400 + (32'($urandom_range(0, 3)) << 2);
      wd  = $urandom;
      lat = $urandom_range(0, 3);
      sn  = ($urandom_range(0, 3) == 0);
      sh  = !sn && ($urandom_range(0, 3) == 0);
      rn  = $urandom_range(0, 1) == 1;
      case (op)
        0: do_txn(1, 0, 0, a, wd, lat, sn, sh, sa);
        1: do_txn(rn, 1, 0, a, wd, lat, sn, sh, sa);
        2: do_txn(1, 0, 1, a, wd, lat, sn, sh, sa);
        3: begin
          if ($urandom_range(0, 1) == 1) a = m_link_a;
          do_txn(rn, 1, 1, a, wd, lat, sn, sh, sa);
        end
        default: begin
          if (rn) idle_snoop(sa);
          else flushed_load(a);
        end
      endcase
    end

    do_txn(1, 0, 1, 32'h500, 32'd0, 0, 0, 0, 32'd0);
    @(negedge CLK);
    resp_lat = 30;
    req_wen = 1'b1; req_addr = 32'h5F0; req_wdat = 32'h77;
    @(negedge CLK);
    @(negedge CLK);
    chk("pre_rst_wen", {31'd0, dmemWEN}, 32'd1);
    nRST = 1'b0;
    req_wen = 1'b0;
    #1;
    exp_acc.delete();
    m_link_v = 1'b0;
    m_stall  = 32'd0;
    chk("arst_wen", {31'd0, dmemWEN}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_done", {31'd0, mem_done}, 32'd0);
    chk("arst_link", {31'd0, link_valid}, 32'd0);
    chk("arst_cnt", stall_cycles, 32'd0);
    chk("arst_addr", dmemaddr, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    resp_lat = 0;
    @(negedge CLK);
    chk("post_rst_done", {31'd0, mem_done}, 32'd0);
    do_txn(1, 0, 0, 32'h5F0, 32'd0, 0, 0, 0, 32'd0);

    @(negedge CLK);
    s_req_ren = 1'b1; s_req_addr = 32'h40; s_dmemload = 32'h0BADF00D;
    repeat (20) @(negedge CLK);
    chk("sat_cnt", {28'd0, s_stall_cycles}, 32'd15);
    chk("sat_stall", {31'd0, s_stall}, 32'd1);
    s_dhit = 1'b1;
    @(negedge CLK);
    s_dhit = 1'b0;
    s_req_ren = 1'b0;
    chk("sat_done", {31'd0, s_mem_done}, 32'd1);
    chk("sat_rdata", s_mem_rdata, 32'h0BADF00D);
    chk("sat_cnt_hold", {28'd0, s_stall_cycles}, 32'd15);

    repeat (4) @(negedge CLK);
    chk("acc_queue_empty", 32'(exp_acc.size()), 32'd0);
    chk("res_queue_empty", 32'(exp_res.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
